// File: rtl/sdf_pkg.sv
// sdf_pkg
// Shared definitions for the single-delay-feedback (SDF) NTT/INTT stage
// controllers of the sdf_16 pipeline.
//   BFU_SEL_NTT / BFU_SEL_INTT : butterfly-unit mux select words, ordered
//                                {a_mod_add_out, b_reg4, mod_add_out_reg4,
//                                 b_mod_sub_out, a_mod_mul_out,
//                                 mod_sub_out_mod_mul_out}
//   sdf_state_e                : controller FSM state encoding
//   tw_addr_width()            : width of the twiddle ROM address for a
//                                transform of size 2**log2n
package sdf_pkg;

  localparam logic [5:0] BFU_SEL_NTT  = 6'b000011;
  localparam logic [5:0] BFU_SEL_INTT = 6'b111100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sdf_state_e;

  // The twiddle ROM holds N/2 entries, so it needs log2n-1 address bits.
  // A degenerate 2-point transform still gets a 1-bit port so the vector
  // never collapses to zero width.
  function automatic int tw_addr_width(input int log2n);
    return (log2n > 1) ? (log2n - 1) : 1;
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl
// Control sequencer for one radix-2 SDF NTT/INTT stage. The stage datapath
// registers its input sample by one cycle, so every control produced here
// is registered too: the controls for a sample appear the cycle after the
// sample's in_valid, lined up with the datapath's input register.
//
// Parameters
//   log2n : transform size N = 2**log2n
//   index : delay-buffer depth D = 2**index, legal range 0..log2n-1
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : one-cycle block start, honoured only in IDLE
//   in_valid                 : stage input sample present (used in RUN only)
//   intt_mode                : 0 = NTT, 1 = INTT, latched on accepted start
//   buffer_enable            : shift the delay buffer
//   buffer_in_mux_selector   : 1 = stage input into buffer, 0 = BFU out 2
//   buffer_out_mux_selector  : 1 = BFU out 1 to stage output, 0 = buffer out
//   bfu_sel                  : butterfly datapath selects, constant per block
//   intt_logic_enable        : latched mode while busy
//   tw_addr                  : twiddle ROM address
//   out_valid                : stage output carries a valid result
//   busy                     : controller is working on a block
//   done                     : one-cycle pulse on the final out_valid
module sdf_stage_ctrl
  import sdf_pkg::*;
#(
  parameter int log2n = 4,
  parameter int index = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic                             intt_mode,
  output logic                             buffer_enable,
  output logic                             buffer_in_mux_selector,
  output logic                             buffer_out_mux_selector,
  output logic [5:0]                       bfu_sel,
  output logic                             intt_logic_enable,
  output logic [tw_addr_width(log2n)-1:0]  tw_addr,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int TW_W     = tw_addr_width(log2n);
  localparam int N        = 1 << log2n;
  localparam int D        = 1 << index;
  // Stage s with depth D walks the twiddle table with stride N/(2D).
  localparam int TW_SHIFT = log2n - 1 - index;

  localparam logic [log2n-1:0] CNT_LAST   = log2n'(N - 1);
  localparam logic [log2n-1:0] CNT_FILLED = log2n'(D);
  localparam logic [log2n-1:0] LOW_MASK   = log2n'(D - 1);
  localparam logic [log2n-1:0] FLUSH_LOAD = log2n'(D - 1);

  sdf_state_e       state;
  logic [log2n-1:0] cnt;
  logic [log2n-1:0] flush_cnt;

  logic             phase;
  logic [log2n-1:0] cnt_low;
  logic [TW_W-1:0]  tw_next;

  // Bit 'index' of the sample counter alternates every D samples between
  // filling the buffer (0) and running the butterfly (1). The low bits give
  // the position inside a butterfly group, which is masked rather than
  // sliced so that index = 0 (no low bits, tw_addr always 0) needs no
  // special case.
  assign phase   = cnt[index];
  assign cnt_low = cnt & LOW_MASK;
  assign tw_next = TW_W'(cnt_low << TW_SHIFT);

  // Single sequential block: FSM, sample counter, flush counter and all
  // registered outputs. In IDLE the outputs are driven to 0 each cycle, so
  // the last block's done/out_valid drop one cycle after the FSM returns.
  // The flush counter drains the final D samples still sitting in the delay
  // buffer after the last input, giving N out_valid cycles per block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= IDLE;
      cnt                     <= '0;
      flush_cnt               <= '0;
      buffer_enable           <= 1'b0;
      buffer_in_mux_selector  <= 1'b0;
      buffer_out_mux_selector <= 1'b0;
      bfu_sel                 <= '0;
      intt_logic_enable       <= 1'b0;
      tw_addr                 <= '0;
      out_valid               <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          buffer_enable           <= 1'b0;
          buffer_in_mux_selector  <= 1'b0;
          buffer_out_mux_selector <= 1'b0;
          bfu_sel                 <= '0;
          intt_logic_enable       <= 1'b0;
          tw_addr                 <= '0;
          out_valid               <= 1'b0;
          busy                    <= 1'b0;
          done                    <= 1'b0;
          if (start) begin
            state             <= RUN;
            cnt               <= '0;
            busy              <= 1'b1;
            intt_logic_enable <= intt_mode;
            bfu_sel           <= intt_mode ? BFU_SEL_INTT : BFU_SEL_NTT;
          end
        end

        RUN: begin
          done <= 1'b0;
          if (in_valid) begin
            buffer_enable           <= 1'b1;
            buffer_in_mux_selector  <= ~phase;
            buffer_out_mux_selector <= phase;
            tw_addr                 <= phase ? tw_next : '0;
            // The first D samples only fill the buffer and produce nothing.
            out_valid               <= (cnt >= CNT_FILLED);
            cnt                     <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end else begin
            // Stall: freeze the buffer, selects and tw_addr keep their value.
            buffer_enable <= 1'b0;
            out_valid     <= 1'b0;
          end
        end

        FLUSH: begin
          buffer_enable           <= 1'b1;
          buffer_in_mux_selector  <= 1'b1;
          buffer_out_mux_selector <= 1'b0;
          tw_addr                 <= '0;
          out_valid               <= 1'b1;
          if (flush_cnt == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl
// Self-checking bench for sdf_stage_ctrl with log2n = 4, index = 2.
// The reference model works per sample: sample k's controls follow from
// k / D (fill or butterfly), k % D (twiddle step) and k >= D (output valid),
// followed by D flush cycles. Outputs are sampled 1 time unit after each
// rising edge and inputs are changed at the same moment.
module tb_sdf_stage_ctrl;

  localparam int LOG2N = 4;
  localparam int INDEX = 2;
  localparam int N     = 16;
  localparam int D     = 4;

  localparam logic [5:0] SEL_NTT  = 6'b000011;
  localparam logic [5:0] SEL_INTT = 6'b111100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       intt_mode = 1'b0;
  logic       buffer_enable;
  logic       buffer_in_mux_selector;
  logic       buffer_out_mux_selector;
  logic [5:0] bfu_sel;
  logic       intt_logic_enable;
  logic [2:0] tw_addr;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct packed {
    logic       be;
    logic       ins;
    logic       outs;
    logic [5:0] bfu;
    logic       intt;
    logic [2:0] tw;
    logic       ov;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  bit   valid_pat[$];

  sdf_stage_ctrl #(
    .log2n(LOG2N),
    .index(INDEX)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .in_valid                (in_valid),
    .intt_mode               (intt_mode),
    .buffer_enable           (buffer_enable),
    .buffer_in_mux_selector  (buffer_in_mux_selector),
    .buffer_out_mux_selector (buffer_out_mux_selector),
    .bfu_sel                 (bfu_sel),
    .intt_logic_enable       (intt_logic_enable),
    .tw_addr                 (tw_addr),
    .out_valid               (out_valid),
    .busy                    (busy),
    .done                    (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_dut();
    obs_t o;
    o.be   = buffer_enable;
    o.ins  = buffer_in_mux_selector;
    o.outs = buffer_out_mux_selector;
    o.bfu  = bfu_sel;
    o.intt = intt_logic_enable;
    o.tw   = tw_addr;
    o.ov   = out_valid;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  // Random in_valid pattern ending exactly on the N-th sample.
  task automatic make_pattern(input int stall_pct);
    int k;
    bit v;
    k = 0;
    valid_pat.delete();
    while (k < N) begin
      v = ($urandom_range(0, 99) >= stall_pct);
      valid_pat.push_back(v);
      if (v) k++;
    end
  endtask

  task automatic contiguous_pattern();
    valid_pat.delete();
    for (int i = 0; i < N; i++) valid_pat.push_back(1'b1);
  endtask

  // Expected output per cycle: entry 0 follows the start edge, entry j
  // follows the edge that consumed valid_pat[j-1], then D flush cycles and
  // one final idle cycle with everything cleared.
  task automatic build_model(input bit mode);
    obs_t cur;
    int   k;
    k = 0;
    exp_q.delete();
    cur      = '0;
    cur.busy = 1'b1;
    cur.intt = mode;
    cur.bfu  = mode ? SEL_INTT : SEL_NTT;
    exp_q.push_back(cur);
    foreach (valid_pat[i]) begin
      if (valid_pat[i]) begin
        cur.be   = 1'b1;
        cur.ins  = ((k / D) % 2) == 0;
        cur.outs = !cur.ins;
        cur.tw   = cur.ins ? 3'd0 : 3'((k % D) * (N / (2 * D)));
        cur.ov   = (k >= D);
        k++;
      end else begin
        cur.be = 1'b0;
        cur.ov = 1'b0;
      end
      exp_q.push_back(cur);
    end
    for (int f = 0; f < D; f++) begin
      cur.be   = 1'b1;
      cur.ins  = 1'b1;
      cur.outs = 1'b0;
      cur.tw   = 3'd0;
      cur.ov   = 1'b1;
      cur.done = (f == D - 1);
      exp_q.push_back(cur);
    end
    exp_q.push_back(obs_t'(0));
  endtask

  // Drives one block from start through the idle cycle after done and
  // records what the DUT shows each cycle. With noise set, start and
  // intt_mode are toggled randomly while the block is in progress.
  task automatic applyStimulus(input bit mode, input bit noise);
    int ncycles;
    ncycles = exp_q.size();
    obs_q.delete();
    start     = 1'b1;
    intt_mode = mode;
    in_valid  = 1'($urandom_range(0, 1));
    for (int j = 0; j < ncycles; j++) begin
      @(posedge clk);
      #1;
      obs_q.push_back(sample_dut());
      start     = (noise && j < ncycles - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      intt_mode = noise ? 1'($urandom_range(0, 1)) : mode;
      in_valid  = (j < valid_pat.size()) ? valid_pat[j] : 1'($urandom_range(0, 1));
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      intt_mode = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_compared++;
      if (sample_dut() !== obs_t'(0)) begin
        n_mismatched++;
        $display("[TB] FAIL reset_hold cycle %0d: got %h, expected 0", i, sample_dut());
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_compared++;
    if (sample_dut() !== obs_t'(0)) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: got %h, expected 0", sample_dut());
    end
  endtask

  task automatic test_ntt_block();
    logic [15:0] ins_exp;
    int ov_count;
    ins_exp = 16'b1111_0000_1111_0000;
    contiguous_pattern();
    build_model(1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_compared++;
      if (obs_q[j] !== exp_q[j]) begin
        n_mismatched++;
        $display("[TB] FAIL ntt_block cycle %0d: got %h, expected %h", j, obs_q[j], exp_q[j]);
      end
    end
    for (int s = 0; s < N; s++) begin
      n_compared++;
      if (obs_q[s + 1].ins !== ins_exp[15 - s] || obs_q[s + 1].outs !== !ins_exp[15 - s]) begin
        n_mismatched++;
        $display("[TB] FAIL ntt_selects sample %0d: got in=%b out=%b, expected in=%b", s, obs_q[s + 1].ins, obs_q[s + 1].outs, ins_exp[15 - s]);
      end
    end
    ov_count = 0;
    for (int j = 1; j <= N + D; j++) begin
      if (obs_q[j].ov === 1'b1) ov_count++;
      n_compared++;
      if (obs_q[j].ov !== (j > D) || obs_q[j].done !== (j == N + D) || obs_q[j].bfu !== SEL_NTT) begin
        n_mismatched++;
        $display("[TB] FAIL ntt_valid_done cycle %0d: got ov=%b done=%b bfu=%b", j, obs_q[j].ov, obs_q[j].done, obs_q[j].bfu);
      end
    end
    n_compared++;
    if (ov_count != N) begin
      n_mismatched++;
      $display("[TB] FAIL ntt_ov_count: got %0d, expected %0d", ov_count, N);
    end
  endtask

  task automatic test_twiddle();
    int tw_exp[8] = '{0, 2, 4, 6, 0, 2, 4, 6};
    int t;
    contiguous_pattern();
    build_model(1'b0);
    applyStimulus(1'b0, 1'b0);
    t = 0;
    foreach (obs_q[j]) begin
      if (obs_q[j].outs === 1'b1) begin
        n_compared++;
        if (t >= 8 || int'(obs_q[j].tw) != tw_exp[t]) begin
          n_mismatched++;
          $display("[TB] FAIL twiddle_step %0d: got %0d, expected %0d", t, obs_q[j].tw, (t < 8) ? tw_exp[t] : -1);
        end
        t++;
      end else if (obs_q[j].tw !== 3'd0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL twiddle_idle cycle %0d: got %0d, expected 0", j, obs_q[j].tw);
      end
    end
    n_compared++;
    if (t != 8) begin
      n_mismatched++;
      $display("[TB] FAIL twiddle_count: got %0d, expected 8", t);
    end
  endtask

  task automatic test_stall();
    int ov_count;
    valid_pat.delete();
    for (int i = 0; i < 5; i++) valid_pat.push_back(1'b1);
    for (int i = 0; i < 3; i++) valid_pat.push_back(1'b0);
    for (int i = 0; i < N - 5; i++) valid_pat.push_back(1'b1);
    build_model(1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_compared++;
      if (obs_q[j] !== exp_q[j]) begin
        n_mismatched++;
        $display("[TB] FAIL stall_block cycle %0d: got %h, expected %h", j, obs_q[j], exp_q[j]);
      end
    end
    // Sample 4 sits in the butterfly phase at twiddle step 0; the stall holds that.
    for (int j = 6; j <= 8; j++) begin
      n_compared++;
      if ({obs_q[j].be, obs_q[j].ins, obs_q[j].outs, obs_q[j].tw, obs_q[j].ov} !== 7'b0_0_1_000_0) begin
        n_mismatched++;
        $display("[TB] FAIL stall_hold cycle %0d: got be=%b in=%b out=%b tw=%0d ov=%b", j, obs_q[j].be, obs_q[j].ins, obs_q[j].outs, obs_q[j].tw, obs_q[j].ov);
      end
    end
    ov_count = 0;
    foreach (obs_q[j]) if (obs_q[j].ov === 1'b1) ov_count++;
    n_compared++;
    if (ov_count != N) begin
      n_mismatched++;
      $display("[TB] FAIL stall_ov_count: got %0d, expected %0d", ov_count, N);
    end
  endtask

  task automatic test_intt_block();
    make_pattern(20);
    build_model(1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_compared++;
      if (obs_q[j] !== exp_q[j]) begin
        n_mismatched++;
        $display("[TB] FAIL intt_block cycle %0d: got %h, expected %h", j, obs_q[j], exp_q[j]);
      end
    end
    for (int j = 0; j < exp_q.size() - 1; j++) begin
      n_compared++;
      if (obs_q[j].intt !== 1'b1 || obs_q[j].bfu !== SEL_INTT) begin
        n_mismatched++;
        $display("[TB] FAIL intt_mode_hold cycle %0d: got intt=%b bfu=%b, expected 1 111100", j, obs_q[j].intt, obs_q[j].bfu);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    contiguous_pattern();
    build_model(1'b0);
    start     = 1'b1;
    intt_mode = 1'b0;
    in_valid  = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (sample_dut() !== exp_q[j]) begin
        n_mismatched++;
        $display("[TB] FAIL mid_run_pre cycle %0d: got %h, expected %h", j, sample_dut(), exp_q[j]);
      end
      start    = 1'b0;
      in_valid = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (sample_dut() !== obs_t'(0)) begin
      n_mismatched++;
      $display("[TB] FAIL mid_run_async_clear: got %h, expected 0", sample_dut());
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (sample_dut() !== obs_t'(0)) begin
      n_mismatched++;
      $display("[TB] FAIL mid_run_held: got %h, expected 0", sample_dut());
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_compared++;
      if (obs_q[j] !== exp_q[j]) begin
        n_mismatched++;
        $display("[TB] FAIL mid_run_fresh cycle %0d: got %h, expected %h", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit mode;
    for (int b = 0; b < 2; b++) begin
      mode = bit'(b);
      make_pattern(0);
      build_model(mode);
      applyStimulus(mode, 1'b0);
      for (int j = 0; j < exp_q.size(); j++) begin
        n_compared++;
        if (obs_q[j] !== exp_q[j]) begin
          n_mismatched++;
          $display("[TB] FAIL back_to_back block %0d cycle %0d: got %h, expected %h", b, j, obs_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_random_blocks();
    bit mode;
    for (int b = 0; b < 5; b++) begin
      mode = 1'($urandom_range(0, 1));
      make_pattern(int'($urandom_range(10, 50)));
      build_model(mode);
      applyStimulus(mode, 1'b1);
      for (int j = 0; j < exp_q.size(); j++) begin
        n_compared++;
        if (obs_q[j] !== exp_q[j]) begin
          n_mismatched++;
          $display("[TB] FAIL random_block %0d cycle %0d: got %h, expected %h", b, j, obs_q[j], exp_q[j]);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_ntt_block();
    test_twiddle();
    test_stall();
    test_intt_block();
    test_reset_mid_run();
    test_back_to_back();
    test_random_blocks();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
